// File: rtl/aud_mode_ctrl.sv
// aud_mode_ctrl: record/play mode controller for the audio path.
// Decodes single-cycle key pulses into a five-state sequencer, issues
// one-cycle start/pause/stop pulses to the recorder and the player, and
// gives exclusive ownership of the single SRAM port to the active side.
// The last recorded address is tracked so that playback stops by itself
// at the end of the clip.
module aud_mode_ctrl #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_record,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic              i_rec_wr_req,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [15:0]       i_rec_data,
    input  logic              i_play_rd_req,
    input  logic [ADDR_W-1:0] i_play_addr,
    input  logic [15:0]       i_sram_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [15:0]       o_sram_wdata,
    output logic [15:0]       o_play_rdata,
    output logic              o_play_rvalid,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_play_start,
    output logic              o_play_pause,
    output logic              o_play_stop,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_end_valid
);

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REC        = 3'd1,
        ST_REC_PAUSE  = 3'd2,
        ST_PLAY       = 3'd3,
        ST_PLAY_PAUSE = 3'd4
    } state_t;

    state_t state;

    // SRAM ownership: only the side whose running state is active may
    // touch the port; requests arriving in any other state are dropped.
    logic wr_acc;
    logic rd_acc;
    // End conditions that terminate a session without a key press.
    logic rec_full;
    logic clip_end;
    // Read issued last cycle; its data is on i_sram_rdata now.
    logic rd_vld_p1;

    assign wr_acc   = i_rec_wr_req  && (state == ST_REC);
    assign rd_acc   = i_play_rd_req && (state == ST_PLAY);
    assign rec_full = wr_acc && (i_rec_addr == MAX_ADDR);
    assign clip_end = rd_acc && (i_play_addr == o_end_addr);

    assign o_state = state;

    // Mode sequencer: key decode (stop > pause > record > play), control
    // pulses and end-of-recording bookkeeping, all registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_play_start <= 1'b0;
            o_play_pause <= 1'b0;
            o_play_stop  <= 1'b0;
            o_end_addr   <= '0;
            o_end_valid  <= 1'b0;
        end else begin
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_play_start <= 1'b0;
            o_play_pause <= 1'b0;
            o_play_stop  <= 1'b0;

            // Every accepted write extends the recording.
            if (wr_acc) begin
                o_end_addr  <= i_rec_addr;
                o_end_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    // Stop and pause have nothing to act on here.
                    if (i_key_record) begin
                        state       <= ST_REC;
                        o_rec_start <= 1'b1;
                        o_end_valid <= 1'b0;
                    end else if (i_key_play && o_end_valid) begin
                        state        <= ST_PLAY;
                        o_play_start <= 1'b1;
                    end
                end
                ST_REC: begin
                    // A full memory ends the take even if pause was pressed.
                    if (i_key_stop || rec_full) begin
                        state      <= ST_IDLE;
                        o_rec_stop <= 1'b1;
                    end else if (i_key_pause) begin
                        state       <= ST_REC_PAUSE;
                        o_rec_pause <= 1'b1;
                    end
                end
                ST_REC_PAUSE: begin
                    if (i_key_stop) begin
                        state      <= ST_IDLE;
                        o_rec_stop <= 1'b1;
                    end else if (i_key_pause || i_key_record) begin
                        state       <= ST_REC;
                        o_rec_start <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Reaching the last recorded word behaves like stop.
                    if (i_key_stop || clip_end) begin
                        state       <= ST_IDLE;
                        o_play_stop <= 1'b1;
                    end else if (i_key_pause) begin
                        state        <= ST_PLAY_PAUSE;
                        o_play_pause <= 1'b1;
                    end
                end
                ST_PLAY_PAUSE: begin
                    if (i_key_stop) begin
                        state       <= ST_IDLE;
                        o_play_stop <= 1'b1;
                    end else if (i_key_pause || i_key_play) begin
                        state        <= ST_PLAY;
                        o_play_start <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM port register: one-cycle write strobe, address held between
    // accesses, write data forced to zero whenever no write is in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sram_we_n  <= 1'b1;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
        end else begin
            o_sram_we_n  <= !wr_acc;
            o_sram_wdata <= wr_acc ? i_rec_data : {DATA_W{1'b0}};
            if (wr_acc) begin
                o_sram_addr <= i_rec_addr;
            end else if (rd_acc) begin
                o_sram_addr <= i_play_addr;
            end
        end
    end

    // Read return path: address goes out at p1, data is captured from the
    // SRAM and presented to the player one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_vld_p1     <= 1'b0;
            o_play_rvalid <= 1'b0;
            o_play_rdata  <= '0;
        end else begin
            // ---- stage p1: address registered on the SRAM pins ----
            rd_vld_p1     <= rd_acc;
            // ---- stage p2: SRAM data captured for the player ----
            o_play_rvalid <= rd_vld_p1;
            if (rd_vld_p1) begin
                o_play_rdata <= i_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed testbench for aud_mode_ctrl with hand-computed expectations.
module tb_aud_mode_ctrl;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_record, key_play, key_pause, key_stop;
    logic              rec_wr_req;
    logic [ADDR_W-1:0] rec_addr;
    logic [15:0]       rec_data;
    logic              play_rd_req;
    logic [ADDR_W-1:0] play_addr;
    logic [15:0]       sram_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic [15:0]       sram_wdata;
    logic [15:0]       play_rdata;
    logic              play_rvalid;
    logic              rec_start, rec_pause, rec_stop;
    logic              play_start, play_pause, play_stop;
    logic [2:0]        state;
    logic [ADDR_W-1:0] end_addr;
    logic              end_valid;

    int errors = 0;
    int checks = 0;

    aud_mode_ctrl #(.ADDR_W(ADDR_W), .MAX_ADDR(20'hFFFFF)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_record  (key_record),
        .i_key_play    (key_play),
        .i_key_pause   (key_pause),
        .i_key_stop    (key_stop),
        .i_rec_wr_req  (rec_wr_req),
        .i_rec_addr    (rec_addr),
        .i_rec_data    (rec_data),
        .i_play_rd_req (play_rd_req),
        .i_play_addr   (play_addr),
        .i_sram_rdata  (sram_rdata),
        .o_sram_addr   (sram_addr),
        .o_sram_we_n   (sram_we_n),
        .o_sram_wdata  (sram_wdata),
        .o_play_rdata  (play_rdata),
        .o_play_rvalid (play_rvalid),
        .o_rec_start   (rec_start),
        .o_rec_pause   (rec_pause),
        .o_rec_stop    (rec_stop),
        .o_play_start  (play_start),
        .o_play_pause  (play_pause),
        .o_play_stop   (play_stop),
        .o_state       (state),
        .o_end_addr    (end_addr),
        .o_end_valid   (end_valid)
    );

    always #5 clk = ~clk;

    // Pulses packed as {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}
    logic [5:0] pulses;
    assign pulses = {rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        key_record = (which == 0);
        key_play   = (which == 1);
        key_pause  = (which == 2);
        key_stop   = (which == 3);
        tick();
        key_record = 1'b0;
        key_play   = 1'b0;
        key_pause  = 1'b0;
        key_stop   = 1'b0;
    endtask

    localparam int K_REC = 0, K_PLAY = 1, K_PAUSE = 2, K_STOP = 3;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key_record = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
        rec_wr_req = 1'b0; rec_addr = '0; rec_data = '0;
        play_rd_req = 1'b0; play_addr = '0; sram_rdata = 16'hABCD;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_state", state, 0);
        chk("rst_pulses", pulses, 0);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", play_rdata, 0);
        chk("rst_rvalid", play_rvalid, 0);
        chk("rst_end", {end_valid, end_addr}, 0);

        // Record start, one-cycle pulse
        press(K_REC);
        chk("rec_state", state, 1);
        chk("rec_start", pulses, 6'b100000);
        tick();
        chk("rec_start_gone", pulses, 0);

        // Three writes at 0,1,2
        for (int i = 0; i < 3; i++) begin
            rec_wr_req = 1'b1;
            rec_addr   = ADDR_W'(i);
            rec_data   = 16'h1111;
            tick();
            chk("wr_we_n", sram_we_n, 0);
            chk("wr_addr", sram_addr, i);
            chk("wr_data", sram_wdata, 16'h1111);
        end
        rec_wr_req = 1'b0;
        tick();
        chk("wr_idle_we_n", sram_we_n, 1);
        chk("wr_idle_wdata", sram_wdata, 0);
        chk("wr_idle_addr_hold", sram_addr, 2);

        // Stop recording
        press(K_STOP);
        chk("stop_state", state, 0);
        chk("stop_pulse", pulses, 6'b001000);
        chk("end_addr", end_addr, 2);
        chk("end_valid", end_valid, 1);

        // Playback with back-to-back reads; auto-stop at addr 2
        press(K_PLAY);
        chk("play_state", state, 3);
        chk("play_start", pulses, 6'b000100);
        play_rd_req = 1'b1;
        play_addr   = 20'd0;
        tick();
        chk("rd0_addr", sram_addr, 0);
        chk("rd0_rvalid_early", play_rvalid, 0);
        play_addr = 20'd1;
        tick();
        chk("rd0_rvalid", play_rvalid, 1);
        chk("rd0_rdata", play_rdata, 16'hABCD);
        chk("rd1_addr", sram_addr, 1);
        play_addr = 20'd2;
        tick();
        chk("rd1_rvalid", play_rvalid, 1);
        chk("clip_end_stop", pulses, 6'b000001);
        chk("clip_end_state", state, 0);
        play_rd_req = 1'b0;
        tick();
        chk("rd2_rvalid", play_rvalid, 1);
        chk("rd2_addr", sram_addr, 2);
        chk("stop_gone", pulses, 0);
        tick();
        chk("rvalid_done", play_rvalid, 0);

        // Empty recording: play is refused
        press(K_REC);
        chk("rec2_end_valid", end_valid, 0);
        press(K_STOP);
        chk("rec2_state", state, 0);
        press(K_PLAY);
        chk("play_refused_state", state, 0);
        chk("play_refused_pulse", pulses, 0);
        rec_wr_req = 1'b1; rec_addr = 20'd5; rec_data = 16'h5555;
        tick();
        rec_wr_req = 1'b0;
        chk("idle_wr_dropped", sram_we_n, 1);
        play_rd_req = 1'b1; play_addr = 20'd0;
        tick();
        play_rd_req = 1'b0;
        tick();
        chk("idle_rd_dropped", play_rvalid, 0);

        // Record pause / resume; write while paused ignored
        press(K_REC);
        press(K_PAUSE);
        chk("rpause_state", state, 2);
        chk("rpause_pulse", pulses, 6'b010000);
        rec_wr_req = 1'b1; rec_addr = 20'd7; rec_data = 16'h2222;
        tick();
        rec_wr_req = 1'b0;
        chk("paused_wr_we_n", sram_we_n, 1);
        chk("paused_wr_end_valid", end_valid, 0);
        press(K_PAUSE);
        chk("resume_state", state, 1);
        chk("resume_pulse", pulses, 6'b100000);
        rec_wr_req = 1'b1; rec_addr = 20'd3; rec_data = 16'h3333;
        tick();
        rec_wr_req = 1'b0;
        chk("resume_wr_data", sram_wdata, 16'h3333);
        press(K_STOP);
        chk("rec3_end", {end_valid, end_addr}, {1'b1, 20'd3});

        // Simultaneous stop + pause in PLAY
        press(K_PLAY);
        chk("play2_state", state, 3);
        key_stop = 1'b1; key_pause = 1'b1;
        tick();
        key_stop = 1'b0; key_pause = 1'b0;
        chk("stop_pause_state", state, 0);
        chk("stop_pause_pulse", pulses, 6'b000001);

        // Memory full auto-stop
        press(K_REC);
        rec_wr_req = 1'b1; rec_addr = 20'hFFFFF; rec_data = 16'h5A5A;
        tick();
        rec_wr_req = 1'b0;
        chk("full_we_n", sram_we_n, 0);
        chk("full_state", state, 0);
        chk("full_pulse", pulses, 6'b001000);
        chk("full_end_addr", end_addr, 20'hFFFFF);

        // Reset from PLAY_PAUSE
        press(K_PLAY);
        press(K_PAUSE);
        chk("ppause_state", state, 4);
        chk("ppause_pulse", pulses, 6'b000010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_pulses", pulses, 0);
        chk("mid_rst_end", {end_valid, end_addr}, 0);
        chk("mid_rst_port", {sram_we_n, sram_addr, sram_wdata}, {1'b1, 20'd0, 16'd0});
        chk("mid_rst_rdata", {play_rvalid, play_rdata}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
